ball_motion: RTL and testbench
==============================

Name: ball_motion

Overview:
- Ball position/velocity engine for the 640x400 pong field.
- Consumes the 3-bit collision code from the collision stage and produces the XCord/YCord that stage checks.
- Also owns serve/miss sequencing and hit/miss counters.
- Moves the ball one step per movement tick, reflects on wall/ceiling/floor/paddle codes, and treats a net code as a miss.

Parameters:
- START_X, 320, X position loaded at reset and at each serve.
- START_Y, 232, Y position loaded at reset and at each serve.
- STEP, 2, pixels moved per tick on each axis (1..15).
- TICK_DIV, 416667, Clk cycles per movement tick (>=2).
- XMAX, 639, X clamp upper bound.
- YMAX, 399, Y clamp upper bound.
- MISS_HOLD, 60, ticks the ball freezes after a miss.
- MAX_MISS, 5, misses that end the game (1..15).

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- ColOut  in  3  collision code: 000 none, 001 paddle, 011 net, 010 ceiling, 110 floor, 100 wall.
- Serve  in  1  level; launches ball from IDLE.
- XCord  out  10  ball X, registered.
- YCord  out  10  ball Y, registered.
- DirX  out  1  1 = +X (toward paddle/net), 0 = -X.
- DirY  out  1  1 = +Y (down), 0 = -Y.
- InPlay  out  1  high only in state PLAY.
- GameOver  out  1  high only in state OVER.
- Hits  out  8  paddle hits, saturating at 255.
- Misses  out  4  misses, saturating at 15.

Behaviour:
- Reset, synchronous: XCord=START_X, YCord=START_Y, DirX=1, DirY=1, Hits=0, Misses=0, tick counter=0, hold counter=0, state=IDLE, InPlay=0, GameOver=0.
- Reset wins over every other event on the same edge, including mid-PLAY and mid-MISS.
- Tick counter:
  - Runs 0..TICK_DIV-1 in all states except OVER; wraps to 0.
  - tick=1 on the cycle the counter equals TICK_DIV-1.
- State IDLE:
  - Position held at START_X/START_Y.
  - Serve=1 on any cycle -> PLAY on the next edge.
  - The tick counter is not reset, so the first move occurs 1..TICK_DIV cycles later.
- State PLAY:
  - On non-tick cycles, ColOut is ignored and nothing changes.
  - On a tick cycle, ColOut is sampled and resolved as follows, then the move applies.
  - 001 with DirX=1: DirX<=0, Hits+1 saturating.
  - 100 with DirX=0: DirX<=1.
  - 010 with DirY=0: DirY<=1.
  - 110 with DirY=1: DirY<=0.
  - A code whose surface lies behind the current direction (stale code from the pipelined collision stage) causes no change.
  - 011: no move; Misses+1 saturating; hold counter<=0; next state is OVER if the incremented Misses >= MAX_MISS, else MISS.
  - Move: each axis adds +STEP or -STEP using the post-reflection direction, in the same edge, so there is 1-cycle latency from the tick to the new XCord/YCord.
  - Clamp: result below 0 -> 0; X above XMAX -> XMAX; Y above YMAX -> YMAX. Compute in 11-bit signed, then truncate.
  - Serve is ignored.
- State MISS:
  - Position frozen; hold counter increments per tick.
  - On the tick where hold counter = MISS_HOLD-1: XCord=START_X, YCord=START_Y, DirX=1, DirY unchanged, state -> IDLE.
  - Serve is ignored.
- State OVER:
  - Everything frozen, GameOver=1; exit only via Rst.
- Hits and Misses change only as described; no wrap.

Test Plan:
- TICK_DIV=4, STEP=2, hold Rst 2 cycles -> XCord=320, YCord=232, DirX=1, DirY=1, Hits=0, Misses=0, InPlay=0.
- Serve pulse, ColOut=000 -> InPlay=1; after 3 ticks XCord=326, YCord=238, exactly 4 cycles between updates.
- In PLAY with DirX=1, ColOut=001 for 3 consecutive ticks -> DirX=0 and Hits=1 (stale repeats ignored); XCord decreases by 2 per tick.
- Ball at Y=1, DirY=0, ColOut=000 -> YCord clamps to 0. Next tick ColOut=010 -> DirY=1, YCord=2.
- ColOut=011 on a tick with MAX_MISS=5 and MISS_HOLD=3:
  - Misses=1; XCord/YCord frozen for 3 ticks, then return to 320/232 in IDLE.
  - Serve asserted during MISS is ignored.
- Fifth net code -> GameOver=1, state OVER, Serve ignored. Rst mid-PLAY on another run -> all reset values on the next edge.

Source files
------------

// File: rtl/ball_motion.sv
// Ball position/velocity engine for the 640x400 pong field: steps the
// ball per movement tick, reflects on collision codes, sequences serve/miss.
// Ports: Clk/Rst (sync, active-high), ColOut collision code, Serve level;
// XCord/YCord/DirX/DirY ball state, InPlay/GameOver status, Hits/Misses.
module ball_motion #(
  parameter int START_X   = 320,
  parameter int START_Y   = 232,
  parameter int STEP      = 2,
  parameter int TICK_DIV  = 416667,
  parameter int XMAX      = 639,
  parameter int YMAX      = 399,
  parameter int MISS_HOLD = 60,
  parameter int MAX_MISS  = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [2:0] ColOut,
  input  logic       Serve,
  output logic [9:0] XCord,
  output logic [9:0] YCord,
  output logic       DirX,
  output logic       DirY,
  output logic       InPlay,
  output logic       GameOver,
  output logic [7:0] Hits,
  output logic [3:0] Misses
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(MISS_HOLD + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MISS_HOLD - 1);
  localparam logic [9:0] SX = 10'(START_X);
  localparam logic [9:0] SY = 10'(START_Y);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] XMAX_S = 11'(XMAX);
  localparam logic signed [10:0] YMAX_S = 11'(YMAX);
  localparam logic [3:0] MAXM = 4'(MAX_MISS);

  localparam logic [2:0] C_PADDLE = 3'b001;
  localparam logic [2:0] C_NET    = 3'b011;
  localparam logic [2:0] C_CEIL   = 3'b010;
  localparam logic [2:0] C_FLOOR  = 3'b110;
  localparam logic [2:0] C_WALL   = 3'b100;

  typedef enum logic [1:0] {
    IDLE, PLAY, MISS, OVER
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            dx_q, dx_d;
  logic            dy_q, dy_d;
  logic [7:0]      hits_q, hits_d;
  logic [3:0]      miss_q, miss_d;
  logic            play_q, over_q;

  logic            tick;
  logic [3:0]      miss_inc;
  logic signed [10:0] nx, ny;

  assign tick     = (cnt_q == TICK_LAST);
  assign miss_inc = (miss_q == 4'hF) ? 4'hF : miss_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    hits_d  = hits_q;
    miss_d  = miss_q;
    nx      = '0;
    ny      = '0;

    if (state_q != OVER)
      cnt_d = tick ? '0 : cnt_q + TW'(1);

    case (state_q)
      IDLE: begin
        x_d = SX;
        y_d = SY;
        if (Serve) state_d = PLAY;
      end
      PLAY: begin
        if (tick) begin
          if (ColOut == C_NET) begin
            miss_d  = miss_inc;
            hold_d  = '0;
            state_d = (miss_inc >= MAXM) ? OVER : MISS;
          end else begin
            // codes facing away from the travel direction are stale
            unique case (ColOut)
              C_PADDLE: if (dx_q) begin
                dx_d   = 1'b0;
                hits_d = (hits_q == 8'hFF) ? 8'hFF : hits_q + 8'd1;
              end
              C_WALL:  if (!dx_q) dx_d = 1'b1;
              C_CEIL:  if (!dy_q) dy_d = 1'b1;
              C_FLOOR: if (dy_q)  dy_d = 1'b0;
              default: ;
            endcase
            nx = $signed({1'b0, x_q}) + (dx_d ? STEP_S : -STEP_S);
            ny = $signed({1'b0, y_q}) + (dy_d ? STEP_S : -STEP_S);
            if (nx < 0)           nx = '0;
            else if (nx > XMAX_S) nx = XMAX_S;
            if (ny < 0)           ny = '0;
            else if (ny > YMAX_S) ny = YMAX_S;
            x_d = nx[9:0];
            y_d = ny[9:0];
          end
        end
      end
      MISS: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            x_d     = SX;
            y_d     = SY;
            dx_d    = 1'b1;
            state_d = IDLE;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      x_q     <= SX;
      y_q     <= SY;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      hits_q  <= '0;
      miss_q  <= '0;
      play_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      hits_q  <= hits_d;
      miss_q  <= miss_d;
      play_q  <= (state_d == PLAY);
      over_q  <= (state_d == OVER);
    end
  end

  assign XCord    = x_q;
  assign YCord    = y_q;
  assign DirX     = dx_q;
  assign DirY     = dy_q;
  assign InPlay   = play_q;
  assign GameOver = over_q;
  assign Hits     = hits_q;
  assign Misses   = miss_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: table of tick-stepped vectors on one
// instance, plus clamp and mid-play reset sequences on a second instance.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       rst[2];
  logic [2:0] col[2];
  logic       srv[2];
  logic [9:0] xc[2];
  logic [9:0] yc[2];
  logic       dx[2];
  logic       dy[2];
  logic       ip[2];
  logic       go[2];
  logic [7:0] hi[2];
  logic [3:0] mi[2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  ball_motion #(
    .START_X(320), .START_Y(232), .STEP(2), .TICK_DIV(4),
    .XMAX(639), .YMAX(399), .MISS_HOLD(3), .MAX_MISS(5)
  ) u0 (
    .Clk(clk), .Rst(rst[0]), .ColOut(col[0]), .Serve(srv[0]),
    .XCord(xc[0]), .YCord(yc[0]), .DirX(dx[0]), .DirY(dy[0]),
    .InPlay(ip[0]), .GameOver(go[0]), .Hits(hi[0]), .Misses(mi[0])
  );

  ball_motion #(
    .START_X(637), .START_Y(3), .STEP(2), .TICK_DIV(4),
    .XMAX(639), .YMAX(399), .MISS_HOLD(3), .MAX_MISS(5)
  ) u1 (
    .Clk(clk), .Rst(rst[1]), .ColOut(col[1]), .Serve(srv[1]),
    .XCord(xc[1]), .YCord(yc[1]), .DirX(dx[1]), .DirY(dy[1]),
    .InPlay(ip[1]), .GameOver(go[1]), .Hits(hi[1]), .Misses(mi[1])
  );

  typedef struct {
    logic [2:0] c;
    logic       s;
    bit         t;
    int         x, y, ddx, ddy, pl, ov, h, m;
  } vec_t;

  vec_t tbl[$];

  task automatic clk1();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // advance to just after the next movement-tick edge
  task automatic to_tick();
    clk1();
    while (cyc % 4 != 0) clk1();
  endtask

  task automatic cmp(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(int d, string nm, int x, int y, int ddx,
                         int ddy, int pl, int ov, int h, int m);
    cmp({nm, ".x"},  16'(xc[d]), 16'(x));
    cmp({nm, ".y"},  16'(yc[d]), 16'(y));
    cmp({nm, ".dx"}, 16'(dx[d]), 16'(ddx));
    cmp({nm, ".dy"}, 16'(dy[d]), 16'(ddy));
    cmp({nm, ".ip"}, 16'(ip[d]), 16'(pl));
    cmp({nm, ".go"}, 16'(go[d]), 16'(ov));
    cmp({nm, ".h"},  16'(hi[d]), 16'(h));
    cmp({nm, ".m"},  16'(mi[d]), 16'(m));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            c       s  t   x    y  dx dy ip go h  m
    tbl.push_back('{3'b000, 1, 0, 320, 232, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{3'b000, 0, 1, 322, 234, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{3'b000, 0, 0, 322, 234, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{3'b000, 0, 0, 322, 234, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{3'b000, 0, 0, 322, 234, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{3'b000, 0, 0, 324, 236, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{3'b000, 0, 1, 326, 238, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{3'b001, 0, 1, 324, 240, 0, 1, 1, 0, 1, 0});
    tbl.push_back('{3'b001, 0, 1, 322, 242, 0, 1, 1, 0, 1, 0});
    tbl.push_back('{3'b001, 0, 1, 320, 244, 0, 1, 1, 0, 1, 0});
    tbl.push_back('{3'b100, 0, 1, 322, 246, 1, 1, 1, 0, 1, 0});
    tbl.push_back('{3'b110, 0, 1, 324, 244, 1, 0, 1, 0, 1, 0});
    tbl.push_back('{3'b110, 0, 1, 326, 242, 1, 0, 1, 0, 1, 0});
    tbl.push_back('{3'b011, 0, 1, 326, 242, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{3'b000, 1, 0, 326, 242, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{3'b000, 1, 1, 326, 242, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{3'b000, 1, 1, 326, 242, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{3'b000, 0, 1, 320, 232, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{3'b000, 0, 0, 320, 232, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{3'b000, 1, 0, 320, 232, 1, 0, 1, 0, 1, 1});
    tbl.push_back('{3'b000, 0, 1, 322, 230, 1, 0, 1, 0, 1, 1});

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      col[d] = 3'b000;
      srv[d] = 1'b0;
    end
    clk1();
    clk1();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    cyc = 0;
    chk_all(0, "rst0", 320, 232, 1, 1, 0, 0, 0, 0);
    chk_all(1, "rst1", 637, 3, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      col[0] = tbl[i].c;
      srv[0] = tbl[i].s;
      if (tbl[i].t) to_tick();
      else clk1();
      chk_all(0, $sformatf("v%0d", i), tbl[i].x, tbl[i].y,
              tbl[i].ddx, tbl[i].ddy, tbl[i].pl, tbl[i].ov,
              tbl[i].h, tbl[i].m);
    end
    srv[0] = 1'b0;

    // misses 2..4: each returns to IDLE, then re-serve
    for (int k = 2; k <= 4; k++) begin
      col[0] = 3'b011;
      to_tick();
      cmp($sformatf("m%0d.m", k), 16'(mi[0]), 16'(k));
      cmp($sformatf("m%0d.ip", k), 16'(ip[0]), 16'd0);
      cmp($sformatf("m%0d.go", k), 16'(go[0]), 16'd0);
      cmp($sformatf("m%0d.x", k), 16'(xc[0]),
          16'((k == 2) ? 322 : 320));
      col[0] = 3'b000;
      to_tick();
      to_tick();
      to_tick();
      chk_all(0, $sformatf("h%0d", k), 320, 232, 1, 0, 0, 0, 1, k);
      srv[0] = 1'b1;
      clk1();
      srv[0] = 1'b0;
      cmp($sformatf("s%0d.ip", k), 16'(ip[0]), 16'd1);
    end

    col[0] = 3'b011;
    to_tick();
    chk_all(0, "over", 320, 232, 1, 0, 0, 1, 1, 5);
    srv[0] = 1'b1;
    col[0] = 3'b001;
    to_tick();
    to_tick();
    chk_all(0, "frz", 320, 232, 1, 0, 0, 1, 1, 5);
    srv[0] = 1'b0;
    col[0] = 3'b000;

    // clamp corners on the second instance
    srv[1] = 1'b1;
    clk1();
    srv[1] = 1'b0;
    cmp("c.ip", 16'(ip[1]), 16'd1);
    col[1] = 3'b110;
    to_tick();
    chk_all(1, "c1", 639, 1, 1, 0, 1, 0, 0, 0);
    col[1] = 3'b000;
    to_tick();
    chk_all(1, "c2", 639, 0, 1, 0, 1, 0, 0, 0);
    col[1] = 3'b010;
    to_tick();
    chk_all(1, "c3", 639, 2, 1, 1, 1, 0, 0, 0);
    col[1] = 3'b100;
    to_tick();
    chk_all(1, "c4", 639, 4, 1, 1, 1, 0, 0, 0);
    col[1] = 3'b001;
    to_tick();
    chk_all(1, "c5", 637, 6, 0, 1, 1, 0, 1, 0);
    col[1] = 3'b000;
    clk1();

    // reset in the middle of play
    rst[1] = 1'b1;
    srv[1] = 1'b1;
    clk1();
    rst[1] = 1'b0;
    srv[1] = 1'b0;
    chk_all(1, "rmid", 637, 3, 1, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
